// File: rtl/itch_msg_framer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | itch_msg_framer_pkg                                                  |
// | Shared ITCH 5.0 types, length table and packed message layouts.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package itch_msg_framer_pkg;

  localparam int ITCH_MAX_BYTES = 40;

  typedef enum logic [7:0] {
    MT_S = 8'h53,
    MT_R = 8'h52,
    MT_A = 8'h41,
    MT_F = 8'h46,
    MT_E = 8'h45,
    MT_C = 8'h43,
    MT_X = 8'h58,
    MT_D = 8'h44,
    MT_U = 8'h55
  } itch_msg_type_e;

  localparam logic [5:0] ITCH_LEN_S = 6'd12;
  localparam logic [5:0] ITCH_LEN_R = 6'd39;
  localparam logic [5:0] ITCH_LEN_A = 6'd36;
  localparam logic [5:0] ITCH_LEN_F = 6'd40;
  localparam logic [5:0] ITCH_LEN_E = 6'd31;
  localparam logic [5:0] ITCH_LEN_C = 6'd36;
  localparam logic [5:0] ITCH_LEN_X = 6'd23;
  localparam logic [5:0] ITCH_LEN_D = 6'd19;
  localparam logic [5:0] ITCH_LEN_U = 6'd35;

  typedef enum logic [2:0] {
    ST_LEN_HI = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_TYPE   = 3'd2,
    ST_BODY   = 3'd3,
    ST_EMIT   = 3'd4,
    ST_DROP   = 3'd5
  } framer_state_e;

  typedef struct packed {
    logic [7:0]  msg_type;
    logic [15:0] stock_locate;
    logic [15:0] tracking_number;
    logic [47:0] timestamp;
    logic [7:0]  event_code;
  } itch_system_event_t;

  typedef struct packed {
    logic [7:0]  msg_type;
    logic [15:0] stock_locate;
    logic [15:0] tracking_number;
    logic [47:0] timestamp;
    logic [63:0] order_ref;
  } itch_order_delete_t;

  // Zero marks a type outside the table.
  function automatic logic [5:0] itch_expected_len(input logic [7:0] t);
    logic [5:0] len;
    case (t)
      MT_S:    len = ITCH_LEN_S;
      MT_R:    len = ITCH_LEN_R;
      MT_A:    len = ITCH_LEN_A;
      MT_F:    len = ITCH_LEN_F;
      MT_E:    len = ITCH_LEN_E;
      MT_C:    len = ITCH_LEN_C;
      MT_X:    len = ITCH_LEN_X;
      MT_D:    len = ITCH_LEN_D;
      MT_U:    len = ITCH_LEN_U;
      default: len = 6'd0;
    endcase
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/itch_msg_framer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | itch_msg_framer_if                                                   |
// | Byte-stream input and framed-message output bundle of the framer.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface itch_msg_framer_if
  import itch_msg_framer_pkg::*;
#(
  parameter int MAX_BYTES = ITCH_MAX_BYTES
) ();

  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [MAX_BYTES*8-1:0] msg_data;
  logic [7:0]             msg_type;
  logic [5:0]             msg_len;
  logic                   msg_valid;
  logic                   msg_ready;
  logic                   err_unknown;
  logic                   err_len;

  // Framer side.
  modport master (
    input  in_data, in_valid, msg_ready,
    output in_ready, msg_data, msg_type, msg_len, msg_valid, err_unknown, err_len
  );

  // Stream source / message sink side.
  modport slave (
    output in_data, in_valid, msg_ready,
    input  in_ready, msg_data, msg_type, msg_len, msg_valid, err_unknown, err_len
  );

endinterface
`default_nettype wire

// File: rtl/itch_msg_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | itch_msg_framer                                                      |
// | Frames length-prefixed ITCH messages into a left-aligned buffer.     |
// | Optional: ITCH_LEN_CHECK_EN drops lengths that disagree with table.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module itch_msg_framer
  import itch_msg_framer_pkg::*;
#(
  parameter int MAX_BYTES = ITCH_MAX_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  itch_msg_framer_if.master bus
);

  localparam int BUF_W = MAX_BYTES * 8;

  framer_state_e    state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [7:0]       type_q, type_d;
  logic [5:0]       msg_len_q, msg_len_d;
  logic             in_ready_q, in_ready_d;
  logic             msg_valid_q, msg_valid_d;
  logic             err_unknown_q, err_unknown_d;
  logic             err_len_q, err_len_d;

  logic             xfer;
  logic [15:0]      len_full;
  logic [5:0]       exp_len;

  assign xfer     = bus.in_valid && in_ready_q;
  assign len_full = {len_q[15:8], bus.in_data};
  assign exp_len  = itch_expected_len(bus.in_data);

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    buf_d         = buf_q;
    type_d        = type_q;
    msg_len_d     = msg_len_q;
    err_unknown_d = 1'b0;
    err_len_d     = 1'b0;

    case (state_q)
      ST_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = bus.in_data;
          state_d     = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          len_d = len_full;
          if (len_full == 16'd0) begin
            state_d = ST_LEN_HI;
          end else if (len_full > 16'(MAX_BYTES)) begin
            err_len_d = 1'b1;
            cnt_d     = len_full;
            state_d   = ST_DROP;
          end else begin
            state_d = ST_TYPE;
          end
        end
      end
      ST_TYPE: begin
        if (xfer) begin
          // Dropped messages never touch the buffer, so it stays zero.
          cnt_d = len_q - 16'd1;
          if (exp_len == 6'd0) begin
            err_unknown_d = 1'b1;
            state_d       = (len_q == 16'd1) ? ST_LEN_HI : ST_DROP;
          end
`ifdef ITCH_LEN_CHECK_EN
          else if (exp_len != len_q[5:0]) begin
            err_len_d = 1'b1;
            state_d   = (len_q == 16'd1) ? ST_LEN_HI : ST_DROP;
          end
`endif
          else begin
            type_d               = bus.in_data;
            buf_d[BUF_W-1 -: 8]  = bus.in_data;
            msg_len_d            = len_q[5:0];
            cnt_d                = 16'd1;
            state_d              = (len_q == 16'd1) ? ST_EMIT : ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (xfer) begin
          for (int i = 0; i < MAX_BYTES; i++) begin
            if (cnt_q[5:0] == 6'(i)) begin
              buf_d[(MAX_BYTES-1-i)*8 +: 8] = bus.in_data;
            end
          end
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == len_q - 16'd1) begin
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (bus.msg_ready) begin
          buf_d     = '0;
          type_d    = '0;
          msg_len_d = '0;
          state_d   = ST_LEN_HI;
        end
      end
      ST_DROP: begin
        if (xfer) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = ST_LEN_HI;
          end
        end
      end
      default: state_d = ST_LEN_HI;
    endcase

    // Handshake outputs follow the next state so both are plain flops.
    in_ready_d  = (state_d != ST_EMIT);
    msg_valid_d = (state_d == ST_EMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_LEN_HI;
      len_q         <= '0;
      cnt_q         <= '0;
      buf_q         <= '0;
      type_q        <= '0;
      msg_len_q     <= '0;
      in_ready_q    <= 1'b0;
      msg_valid_q   <= 1'b0;
      err_unknown_q <= 1'b0;
      err_len_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      buf_q         <= buf_d;
      type_q        <= type_d;
      msg_len_q     <= msg_len_d;
      in_ready_q    <= in_ready_d;
      msg_valid_q   <= msg_valid_d;
      err_unknown_q <= err_unknown_d;
      err_len_q     <= err_len_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.msg_valid   = msg_valid_q;
  assign bus.msg_data    = buf_q;
  assign bus.msg_type    = type_q;
  assign bus.msg_len     = msg_len_q;
  assign bus.err_unknown = err_unknown_q;
  assign bus.err_len     = err_len_q;

endmodule
`default_nettype wire

// File: tb/tb_itch_msg_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_itch_msg_framer                                                   |
// | Directed stream bench with a stream-parsing reference model.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_itch_msg_framer;

`ifdef ITCH_LEN_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [319:0] data;
    logic [7:0]   typ;
    logic [5:0]   len;
  } exp_msg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  itch_msg_framer_if #(.MAX_BYTES(40)) bus_if ();
  itch_msg_framer #(.MAX_BYTES(40)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_msgs = 0;
  int n_unk  = 0;
  int n_len  = 0;

  exp_msg_t   exp_q[$];
  int         exp_err_q[$];
  bit         last_flag[$];
  logic [1:0] err_flag[$];
  byte_q_t    stim;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int table_len(input logic [7:0] t);
    case (t)
      "S": return 12;
      "R": return 39;
      "A": return 36;
      "F": return 40;
      "E": return 31;
      "C": return 36;
      "X": return 23;
      "D": return 19;
      "U": return 35;
      default: return 0;
    endcase
  endfunction

  // Walk the record stream and list what must come out, byte by byte.
  task automatic model_parse(input byte_q_t b);
    int i, len, tl;
    exp_msg_t m;
    last_flag.delete();
    err_flag.delete();
    for (int k = 0; k < b.size(); k++) begin
      last_flag.push_back(1'b0);
      err_flag.push_back(2'b00);
    end
    i = 0;
    while (i + 1 < b.size()) begin
      len = int'({b[i], b[i+1]});
      i += 2;
      if (len == 0) continue;
      if (len > 40) begin
        exp_err_q.push_back(2); err_flag[i-1] = 2'b10; i += len; continue;
      end
      tl = table_len(b[i]);
      if (tl == 0) begin
        exp_err_q.push_back(1); err_flag[i] = 2'b01; i += len; continue;
      end
      if (LEN_CHECK && tl != len) begin
        exp_err_q.push_back(2); err_flag[i] = 2'b10; i += len; continue;
      end
      m.data = '0;
      for (int k = 0; k < len; k++) m.data[319-8*k -: 8] = b[i+k];
      m.typ = b[i];
      m.len = 6'(len);
      exp_q.push_back(m);
      last_flag[i+len-1] = 1'b1;
      i += len;
    end
  endtask

  task automatic push_msg(input logic [7:0] typ, input int len, input int seed);
    stim.push_back(8'(len >> 8));
    stim.push_back(8'(len));
    if (len > 0) stim.push_back(typ);
    for (int k = 1; k < len; k++) stim.push_back(8'(seed + 7 * k));
  endtask

  // Called at a negedge; returns at the negedge after the last transfer.
  task automatic send_bytes(input byte_q_t b, input bit use_flags);
    int t;
    for (int k = 0; k < b.size(); k++) begin
      if (k % 7 == 6) begin
        bus_if.in_valid = 1'b0;
        @(negedge clk);
      end
      bus_if.in_data  = b[k];
      bus_if.in_valid = 1'b1;
      t = 0;
      while (!bus_if.in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) chk("in_ready_timeout", 0, 1);
      @(negedge clk);
      if (use_flags) begin
        chk("valid_on_byte", bus_if.msg_valid, last_flag[k]);
        chk("err_on_byte", {bus_if.err_len, bus_if.err_unknown}, err_flag[k]);
      end
    end
    bus_if.in_valid = 1'b0;
  endtask

  task automatic drain_check();
    repeat (4) @(negedge clk);
    chk("msgs_drained", exp_q.size(), 0);
    chk("errs_drained", exp_err_q.size(), 0);
  endtask

  task automatic run_stream();
    model_parse(stim);
    send_bytes(stim, 1'b1);
    stim.delete();
    drain_check();
  endtask

  // Every-cycle compare against the model queues.
  initial begin : compare
    logic         pv, pr;
    logic [319:0] pd;
    logic [7:0]   pt;
    logic [5:0]   pl;
    exp_msg_t     e;
    int           kind;
    pv = 1'b0; pr = 1'b0; pd = '0; pt = '0; pl = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pv = 1'b0;
        continue;
      end
      if (pv && !pr) begin
        chk("hold_valid", bus_if.msg_valid, 1);
        chk("hold_data", bus_if.msg_data, pd);
        chk("hold_type", bus_if.msg_type, pt);
        chk("hold_len", bus_if.msg_len, pl);
      end
      if (bus_if.msg_valid) begin
        chk("ready_low_in_emit", bus_if.in_ready, 0);
        if (bus_if.msg_ready) begin
          n_msgs++;
          if (exp_q.size() == 0) begin
            chk("unexpected_msg", bus_if.msg_type, 0);
          end else begin
            e = exp_q.pop_front();
            chk("msg_data", bus_if.msg_data, e.data);
            chk("msg_type", bus_if.msg_type, e.typ);
            chk("msg_len", bus_if.msg_len, e.len);
          end
        end
      end
      if (bus_if.err_unknown || bus_if.err_len) begin
        kind = bus_if.err_len ? 2 : 1;
        if (bus_if.err_unknown) n_unk++;
        if (bus_if.err_len) n_len++;
        chk("err_single", {bus_if.err_len, bus_if.err_unknown} != 2'b11, 1);
        if (exp_err_q.size() == 0) chk("unexpected_err", kind, 0);
        else chk("err_kind", kind, exp_err_q.pop_front());
      end
      pv = bus_if.msg_valid;
      pr = bus_if.msg_ready;
      pd = bus_if.msg_data;
      pt = bus_if.msg_type;
      pl = bus_if.msg_len;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int m0, u0, l0, t;
    bus_if.in_data   = 8'h00;
    bus_if.in_valid  = 1'b0;
    bus_if.msg_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus_if.in_ready, 0);
    chk("rst_msg_valid", bus_if.msg_valid, 0);
    chk("rst_msg_data", bus_if.msg_data, 0);
    chk("rst_msg_type", bus_if.msg_type, 0);
    chk("rst_msg_len", bus_if.msg_len, 0);
    chk("rst_errs", {bus_if.err_len, bus_if.err_unknown}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", bus_if.in_ready, 1);

    // 1: system event, literal expectation pins the model
    stim = '{8'h00, 8'h0C, 8'h53, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
             8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h4F};
    model_parse(stim);
    send_bytes(stim, 1'b1);
    stim.delete();
    chk("t1_valid", bus_if.msg_valid, 1);
    chk("t1_type", bus_if.msg_type, 8'h53);
    chk("t1_len", bus_if.msg_len, 12);
    chk("t1_data", bus_if.msg_data, {96'h53000000_00010203_0405064F, 224'h0});
    drain_check();

    // 2: back-to-back A then D with a 5-cycle downstream stall
    m0 = n_msgs;
    push_msg("A", 36, 3);
    push_msg("D", 19, 8'h80);
    model_parse(stim);
    fork
      send_bytes(stim, 1'b1);
      begin
        bus_if.msg_ready = 1'b0;
        t = 0;
        while (!bus_if.msg_valid && t < 500) begin
          @(negedge clk);
          t++;
        end
        chk("t2_stall_seen", bus_if.msg_valid, 1);
        repeat (5) begin
          @(negedge clk);
          chk("t2_stall_in_ready", bus_if.in_ready, 0);
          chk("t2_stall_valid", bus_if.msg_valid, 1);
        end
        bus_if.msg_ready = 1'b1;
      end
    join
    stim.delete();
    drain_check();
    chk("t2_msg_count", n_msgs - m0, 2);

    // 3: zero-length record, unknown type, then an intact S
    m0 = n_msgs; u0 = n_unk;
    stim.push_back(8'h00); stim.push_back(8'h00);
    push_msg(8'h5A, 5, 1);
    push_msg("S", 12, 9);
    run_stream();
    chk("t3_unknown_pulses", n_unk - u0, 1);
    chk("t3_msg_count", n_msgs - m0, 1);

    // 4: oversize 48-byte record fully consumed, next S aligned
    m0 = n_msgs; l0 = n_len;
    push_msg(8'h41, 48, 5);
    push_msg("S", 12, 2);
    run_stream();
    chk("t4_len_pulses", n_len - l0, 1);
    chk("t4_msg_count", n_msgs - m0, 1);

    // 5: S declared as 11 bytes, then D
    m0 = n_msgs; l0 = n_len;
    push_msg("S", 11, 4);
    push_msg("D", 19, 6);
    run_stream();
    chk("t5_len_pulses", n_len - l0, LEN_CHECK ? 1 : 0);
    chk("t5_msg_count", n_msgs - m0, LEN_CHECK ? 1 : 2);

    // 7: boundaries: max length F, 41-byte record, X
    m0 = n_msgs; l0 = n_len;
    push_msg("F", 40, 11);
    push_msg("X", 41, 12);
    push_msg("X", 23, 13);
    run_stream();
    chk("t7_len_pulses", n_len - l0, 1);
    chk("t7_msg_count", n_msgs - m0, 2);

    // 6: async reset in the body of an R message
    push_msg("R", 39, 14);
    while (stim.size() > 12) void'(stim.pop_back());
    send_bytes(stim, 1'b0);
    stim.delete();
    #2 rst = 1'b1;
    #1;
    chk("t6_in_ready", bus_if.in_ready, 0);
    chk("t6_msg_valid", bus_if.msg_valid, 0);
    chk("t6_msg_data", bus_if.msg_data, 0);
    chk("t6_msg_type", bus_if.msg_type, 0);
    chk("t6_msg_len", bus_if.msg_len, 0);
    chk("t6_errs", {bus_if.err_len, bus_if.err_unknown}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m0 = n_msgs; u0 = n_unk; l0 = n_len;
    push_msg("S", 12, 21);
    run_stream();
    chk("t6_msg_count", n_msgs - m0, 1);
    chk("t6_no_errs", (n_unk - u0) + (n_len - l0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
